// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos-map fixed-point datapath blocks
// (shift-add multiplier and restoring divider).
package chaos_pkg;

  localparam int W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Width of an iteration counter that has to hold the value w-1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(W);

endpackage

// File: rtl/seq_div36_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
import chaos_pkg::*;

module div_step #(
  parameter int W = chaos_pkg::W
) (
  input  logic [W-1:0] r_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] d_ext;
  logic       fits;

  // The partial remainder is always below the divisor, so the difference
  // fits in W bits and only the low W bits of the subtraction are needed.
  always_comb begin
    t     = {r_in, bit_in};
    d_ext = {1'b0, divisor};
    fits  = (t >= d_ext);
    q_bit = fits;
    r_out = fits ? (t[W-1:0] - divisor) : t[W-1:0];
  end

endmodule

// File: rtl/seq_div36.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor, one
// quotient bit per clock with a level start/done handshake.
import chaos_pkg::*;

module seq_div36 #(
  parameter int W = chaos_pkg::W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           calc_start,
  input  logic [2*W-1:0] dataa,
  input  logic [W-1:0]   datab,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           done
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [W-1:0]   divisor_q, divisor_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [W-1:0]   step_r;
  logic           step_q;

  // The shift register feeds dividend bits MSB first and fills with
  // quotient bits from the bottom, so it holds the quotient at the end.
  div_step #(.W(W)) u_step (
    .r_in    (rem_q),
    .bit_in  (sh_q[W-1]),
    .divisor (divisor_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sh_d        = sh_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (calc_start) begin
          divisor_d = datab;
          // A high half not below the divisor cannot give a W-bit quotient.
          if (dataa[2*W-1:W] >= datab) begin
            quotient_d  = '1;
            remainder_d = '0;
            ovf_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = dataa[2*W-1:W];
            sh_d    = dataa[W-1:0];
            cnt_d   = CNT_LAST;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        rem_d = step_r;
        sh_d  = {sh_q[W-2:0], step_q};
        if (cnt_q == '0) begin
          quotient_d  = {sh_q[W-2:0], step_q};
          remainder_d = step_r;
          ovf_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: begin
        if (!calc_start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      sh_q        <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sh_q        <= sh_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_div36.sv
// Directed and randomized checks of seq_div36: latency, handshake,
// overflow, asynchronous reset and the division invariant.
module tb_seq_div36;

  logic        CLK;
  logic        RST;
  logic        calc_start;
  logic [35:0] dataa;
  logic [17:0] datab;
  logic [17:0] quotient;
  logic [17:0] remainder;
  logic        ovf;
  logic        done;

  int checks;
  int failures;

  seq_div36 dut (
    .CLK        (CLK),
    .RST        (RST),
    .calc_start (calc_start),
    .dataa      (dataa),
    .datab      (datab),
    .quotient   (quotient),
    .remainder  (remainder),
    .ovf        (ovf),
    .done       (done)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with calc_start high; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [35:0] a, input logic [17:0] b, input bit hold);
    @(negedge CLK);
    dataa      = a;
    datab      = b;
    calc_start = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) calc_start = 1'b0;
  endtask

  // Count edges until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
  endtask

  // Drop calc_start and let the DUT return to IDLE.
  task automatic releaseStart();
    @(negedge CLK);
    calc_start = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          cyc;
    logic [17:0] b;
    logic [17:0] hi;
    logic [17:0] lo;
    logic [35:0] a;
    logic [35:0] recon;

    checks     = 0;
    failures   = 0;
    RST        = 1'b0;
    calc_start = 1'b0;
    dataa      = '0;
    datab      = '0;

    #1;
    checkOutput("reset_quotient", 36'(quotient), 36'h0);
    checkOutput("reset_remainder", 36'(remainder), 36'h0);
    checkOutput("reset_ovf", 36'(ovf), 36'h0);
    checkOutput("reset_done", 36'(done), 36'h0);
    #20;
    @(negedge CLK);
    RST = 1'b1;

    $display("[TB] basic 1000/7 with start held");
    applyStimulus(36'd1000, 18'd7, 1'b1);
    checkOutput("basic_not_done_at_start", 36'(done), 36'h0);
    waitDone(cyc);
    checkOutput("basic_latency", 36'(cyc), 36'd18);
    checkOutput("basic_quotient", 36'(quotient), 36'd142);
    checkOutput("basic_remainder", 36'(remainder), 36'd6);
    checkOutput("basic_ovf", 36'(ovf), 36'h0);
    dataa = 36'd5000;
    datab = 18'd3;
    repeat (25) @(posedge CLK);
    #1;
    checkOutput("hold_done", 36'(done), 36'h1);
    checkOutput("hold_quotient", 36'(quotient), 36'd142);
    checkOutput("hold_remainder", 36'(remainder), 36'd6);
    releaseStart();
    checkOutput("release_done", 36'(done), 36'h0);
    checkOutput("release_quotient_kept", 36'(quotient), 36'd142);
    checkOutput("release_remainder_kept", 36'(remainder), 36'd6);

    $display("[TB] multiplier round trip");
    applyStimulus(36'hFFFF8_0001, 18'h3FFFF, 1'b1);
    waitDone(cyc);
    checkOutput("sq_latency", 36'(cyc), 36'd18);
    checkOutput("sq_quotient", 36'(quotient), 36'h3FFFF);
    checkOutput("sq_remainder", 36'(remainder), 36'h0);
    checkOutput("sq_ovf", 36'(ovf), 36'h0);
    releaseStart();
    applyStimulus(36'h1_2345_6789, 18'h2_0000, 1'b1);
    waitDone(cyc);
    checkOutput("pow2_quotient", 36'(quotient), 36'h091A2);
    checkOutput("pow2_remainder", 36'(remainder), 36'h16789);
    checkOutput("pow2_ovf", 36'(ovf), 36'h0);
    releaseStart();

    $display("[TB] overflow cases");
    applyStimulus(36'd12345, 18'd0, 1'b1);
    @(posedge CLK);
    #1;
    checkOutput("div0_done", 36'(done), 36'h1);
    checkOutput("div0_ovf", 36'(ovf), 36'h1);
    checkOutput("div0_quotient", 36'(quotient), 36'h3FFFF);
    checkOutput("div0_remainder", 36'(remainder), 36'h0);
    releaseStart();
    checkOutput("div0_release_done", 36'(done), 36'h0);
    checkOutput("div0_release_ovf_kept", 36'(ovf), 36'h1);
    applyStimulus(36'h00004_0000, 18'd1, 1'b1);
    @(posedge CLK);
    #1;
    checkOutput("eq_done", 36'(done), 36'h1);
    checkOutput("eq_ovf", 36'(ovf), 36'h1);
    checkOutput("eq_quotient", 36'(quotient), 36'h3FFFF);
    checkOutput("eq_remainder", 36'(remainder), 36'h0);
    releaseStart();

    $display("[TB] one-cycle start pulse");
    applyStimulus(36'd1000, 18'd7, 1'b0);
    waitDone(cyc);
    checkOutput("pulse_latency", 36'(cyc), 36'd18);
    checkOutput("pulse_quotient", 36'(quotient), 36'd142);
    checkOutput("pulse_ovf", 36'(ovf), 36'h0);
    @(posedge CLK);
    #1;
    checkOutput("pulse_done_one_cycle", 36'(done), 36'h0);
    checkOutput("pulse_quotient_kept", 36'(quotient), 36'd142);

    $display("[TB] operands changed mid-computation");
    applyStimulus(36'hFFFF8_0001, 18'h3FFFF, 1'b1);
    repeat (5) @(posedge CLK);
    #1;
    dataa = 36'd1000;
    datab = 18'd7;
    waitDone(cyc);
    checkOutput("midchg_latency", 36'(cyc), 36'd13);
    checkOutput("midchg_quotient", 36'(quotient), 36'h3FFFF);
    checkOutput("midchg_remainder", 36'(remainder), 36'h0);
    releaseStart();

    $display("[TB] asynchronous reset during computation");
    applyStimulus(36'd1000, 18'd7, 1'b1);
    repeat (9) @(posedge CLK);
    #2;
    RST        = 1'b0;
    calc_start = 1'b0;
    #1;
    checkOutput("rst_quotient", 36'(quotient), 36'h0);
    checkOutput("rst_remainder", 36'(remainder), 36'h0);
    checkOutput("rst_ovf", 36'(ovf), 36'h0);
    checkOutput("rst_done", 36'(done), 36'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    checkOutput("rst_no_stale_done", 36'(done), 36'h0);
    applyStimulus(36'd1000, 18'd7, 1'b1);
    waitDone(cyc);
    checkOutput("postrst_latency", 36'(cyc), 36'd18);
    checkOutput("postrst_quotient", 36'(quotient), 36'd142);
    checkOutput("postrst_remainder", 36'(remainder), 36'd6);
    releaseStart();

    $display("[TB] random non-overflow sweep");
    for (int i = 0; i < 300; i++) begin
      b  = 18'($urandom_range(1, 262143));
      hi = 18'($urandom_range(0, int'(b) - 1));
      lo = 18'($urandom_range(0, 262143));
      a  = {hi, lo};
      applyStimulus(a, b, 1'b1);
      waitDone(cyc);
      recon = 36'(quotient) * 36'(b) + 36'(remainder);
      checkOutput("rand_latency", 36'(cyc), 36'd18);
      checkOutput("rand_ovf", 36'(ovf), 36'h0);
      checkOutput("rand_invariant", recon, a);
      checkOutput("rand_rem_lt_div", 36'(remainder < b), 36'h1);
      releaseStart();
    end

    $display("[TB] random overflow sweep");
    for (int i = 0; i < 50; i++) begin
      b  = 18'($urandom_range(0, 262143));
      hi = 18'($urandom_range(int'(b), 262143));
      lo = 18'($urandom_range(0, 262143));
      applyStimulus({hi, lo}, b, 1'b1);
      @(posedge CLK);
      #1;
      checkOutput("rovf_done", 36'(done), 36'h1);
      checkOutput("rovf_ovf", 36'(ovf), 36'h1);
      checkOutput("rovf_quotient", 36'(quotient), 36'h3FFFF);
      checkOutput("rovf_remainder", 36'(remainder), 36'h0);
      releaseStart();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
